hls_mem_responder: RTL and testbench

HLS_MEM_RESPONDER -- requirements
Module: hls_mem_responder

---
 rtl/hls_mem_pkg.sv | 21 ++
 rtl/hls_mem_bram.sv | 32 +++
 rtl/hls_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_hls_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_mem_pkg.sv
// rtl/hls_mem_pkg.sv - shared types, limits and burst sizing for the memory responder
package hls_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int MAX_BEATS = 8;

  // Command size code to number of read beats; sizes 0..2 are single-word reads.
  function automatic logic [3:0] size_to_beats(input logic [2:0] size);
    case (size)
      3'd3:                return 4'd2;
      3'd4:                return 4'd4;
      3'd5, 3'd6, 3'd7:    return 4'(MAX_BEATS);
      default:             return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/hls_mem_bram.sv
// rtl/hls_mem_bram.sv - single-port-style word memory with byte-enable write and registered read
module hls_mem_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Byte-lane write; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // One-cycle registered read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hls_mem_responder.sv
// rtl/hls_mem_responder.sv - command-FIFO driven memory responder with wrapping read bursts (optional HLS_MEM_WRITE_ACK_EN)
module hls_mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_empty_n,
  output logic                    cmd_read,
  input  logic [31:0]             cmd_address,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_mask,
  input  logic                    cmd_write,
  input  logic [2:0]              cmd_size,
  input  logic                    cmd_last,
  output logic [DATA_WIDTH-1:0]   rsp_data_din,
  output logic                    rsp_last_din,
  input  logic                    rsp_full_n,
  output logic                    rsp_write
);

  import hls_mem_pkg::*;

  localparam int AW = MEM_ADDR_WIDTH;

  // Next word inside the aligned block selected by mask (mask = beats-1).
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a, input logic [AW-1:0] m);
    return (a & ~m) | ((a + AW'(1)) & m);
  endfunction

  state_t                       state;
  logic [AW-1:0]                burst_addr;
  logic [AW-1:0]                burst_mask;
  logic [3:0]                   beats_left;

  logic                         fl_valid;
  logic                         fl_last;
  logic                         fl_ack;

  logic [1:0][DATA_WIDTH-1:0]   buf_data;
  logic [1:0]                   buf_last;
  logic                         rd_ptr;
  logic                         wr_ptr;
  logic [1:0]                   count;

  logic                         pop;
  logic [2:0]                   occ;
  logic                         space;
  logic [3:0]                   cmd_beats;
  logic [AW-1:0]                cmd_addr_w;
  logic [AW-1:0]                cmd_mask_w;
  logic                         mem_we;
  logic                         mem_re;
  logic [AW-1:0]                rd_addr;
  logic                         issue;
  logic                         issue_last;
  logic                         issue_ack;
  logic [DATA_WIDTH-1:0]        mem_rdata;
  logic                         unused_bits;

  assign unused_bits = ^{cmd_last, cmd_address[31:AW]};

  assign cmd_beats  = size_to_beats(cmd_size);
  assign cmd_addr_w = cmd_address[AW-1:0];
  assign cmd_mask_w = AW'(cmd_beats - 4'd1);

  // A buffered entry leaving this cycle frees its slot, which keeps one beat per cycle.
  assign pop   = (count != 2'd0) && rsp_full_n;
  assign occ   = {1'b0, count} + {2'b00, fl_valid} - {2'b00, pop};
  assign space = (occ < 3'd2);

  assign rsp_write    = pop;
  assign rsp_data_din = buf_data[rd_ptr];
  assign rsp_last_din = buf_last[rd_ptr];

  // Command acceptance and read/write issue decisions for the current cycle.
  always_comb begin
    cmd_read   = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    rd_addr    = burst_addr;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_ack  = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (cmd_empty_n) begin
            if (cmd_write) begin
`ifdef HLS_MEM_WRITE_ACK_EN
              if (space) begin
                cmd_read   = 1'b1;
                mem_we     = 1'b1;
                issue      = 1'b1;
                issue_ack  = 1'b1;
                issue_last = 1'b1;
              end
`else
              cmd_read = 1'b1;
              mem_we   = 1'b1;
`endif
            end else if (space) begin
              cmd_read   = 1'b1;
              mem_re     = 1'b1;
              rd_addr    = cmd_addr_w;
              issue      = 1'b1;
              issue_last = (cmd_beats == 4'd1);
            end
          end
        end
        BURST: begin
          if (space) begin
            mem_re     = 1'b1;
            issue      = 1'b1;
            issue_last = (beats_left == 4'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // Burst FSM: tracks next wrapped address and remaining beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      burst_addr <= '0;
      burst_mask <= '0;
      beats_left <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue && !issue_ack && !issue_last) begin
            state      <= BURST;
            burst_mask <= cmd_mask_w;
            burst_addr <= wrap_inc(cmd_addr_w, cmd_mask_w);
            beats_left <= cmd_beats - 4'd1;
          end
        end
        BURST: begin
          if (issue) begin
            beats_left <= beats_left - 4'd1;
            burst_addr <= wrap_inc(burst_addr, burst_mask);
            if (issue_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight tag travelling alongside the one-cycle memory read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_valid <= 1'b0;
      fl_last  <= 1'b0;
      fl_ack   <= 1'b0;
    end else begin
      fl_valid <= issue;
      fl_last  <= issue_last;
      fl_ack   <= issue_ack;
    end
  end

  // Two-entry response buffer; holds its contents while the response FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      buf_last <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (fl_valid) begin
        buf_data[wr_ptr] <= fl_ack ? '0 : mem_rdata;
        buf_last[wr_ptr] <= fl_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, fl_valid} - {1'b0, pop};
    end
  end

  hls_mem_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_bram (
    .clk    (clk),
    .wr_en  (mem_we),
    .wr_be  (cmd_mask),
    .wr_addr(cmd_addr_w),
    .wr_data(cmd_data),
    .rd_en  (mem_re),
    .rd_addr(rd_addr),
    .rd_data(mem_rdata)
  );

endmodule

// File: tb/tb_hls_mem_responder.sv
// tb/tb_hls_mem_responder.sv - directed self-checking bench for hls_mem_responder
module tb_hls_mem_responder;

`ifdef HLS_MEM_WRITE_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_empty_n;
  logic        cmd_read;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic        cmd_last;
  logic [31:0] rsp_data_din;
  logic        rsp_last_din;
  logic        rsp_full_n;
  logic        rsp_write;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [31:0] q_data [$];
  logic        q_last [$];
  int          q_cyc  [$];

  hls_mem_responder #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_empty_n (cmd_empty_n),
    .cmd_read    (cmd_read),
    .cmd_address (cmd_address),
    .cmd_data    (cmd_data),
    .cmd_mask    (cmd_mask),
    .cmd_write   (cmd_write),
    .cmd_size    (cmd_size),
    .cmd_last    (cmd_last),
    .rsp_data_din(rsp_data_din),
    .rsp_last_din(rsp_last_din),
    .rsp_full_n  (rsp_full_n),
    .rsp_write   (rsp_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_write) begin
      q_data.push_back(rsp_data_din);
      q_last.push_back(rsp_last_din);
      q_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [2:0] size);
    int n;
    cmd_write   = wr;
    cmd_address = addr;
    cmd_data    = data;
    cmd_mask    = mask;
    cmd_size    = size;
    cmd_last    = 1'b1;
    cmd_empty_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_read && n < 50);
    acc_cyc = cyc;
    checks++;
    if (cmd_read !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept addr=%h got cmd_read=%b expected 1 within 50 cycles", addr, cmd_read);
    end
    @(posedge clk);
    #1 cmd_empty_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    cmd_empty_n = 1'b1;
    cmd_write   = 1'b0;
    cmd_address = 32'h0;
    cmd_data    = 32'h0;
    cmd_mask    = 4'h0;
    cmd_size    = 3'd2;
    cmd_last    = 1'b0;
    rsp_full_n  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_read !== 1'b0) begin errors++; $display("FAIL reset_cmd_read got %b expected 0", cmd_read); end
    checks++;
    if (rsp_write !== 1'b0) begin errors++; $display("FAIL reset_rsp_write got %b expected 0", rsp_write); end
    checks++;
    if (rsp_data_din !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h expected 00000000", rsp_data_din); end
    checks++;
    if (rsp_last_din !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got %b expected 0", rsp_last_din); end
    cmd_empty_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write_read();
    clear_q();
    push_cmd(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 3'd2);
    push_cmd(1'b0, 32'h010, 32'h0, 4'h0, 3'd2);
    idle(8);
    checks++;
    if (q_data.size() != 1 + ACK) begin
      errors++;
      $display("FAIL wr_rd_count got %0d expected %0d", q_data.size(), 1 + ACK);
    end else begin
      checks++;
      if (q_data[ACK] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got %h expected deadbeef", q_data[ACK]); end
      checks++;
      if (q_last[ACK] !== 1'b1) begin errors++; $display("FAIL wr_rd_last got %b expected 1", q_last[ACK]); end
      checks++;
      if (q_cyc[ACK] != acc_cyc + 2) begin errors++; $display("FAIL wr_rd_latency got cycle %0d expected %0d", q_cyc[ACK], acc_cyc + 2); end
    end
  endtask

  task automatic test_byte_mask();
    clear_q();
    push_cmd(1'b1, 32'h020, 32'h11223344, 4'hF, 3'd2);
    push_cmd(1'b1, 32'h020, 32'h000000AA, 4'h1, 3'd2);
    push_cmd(1'b0, 32'h020, 32'h0, 4'h0, 3'd0);
    idle(8);
    checks++;
    if (q_data.size() != 1 + 2*ACK) begin
      errors++;
      $display("FAIL mask_count got %0d expected %0d", q_data.size(), 1 + 2*ACK);
    end else begin
      checks++;
      if (q_data[2*ACK] !== 32'h112233AA) begin errors++; $display("FAIL mask_data got %h expected 112233aa", q_data[2*ACK]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    logic        exp_l [4];
    exp_d = '{32'hE, 32'hF, 32'hC, 32'hD};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h0C + i, 32'hC + i, 4'hF, 3'd2);
    idle(6);
    clear_q();
    push_cmd(1'b0, 32'h0E, 32'h0, 4'h0, 3'd4);
    idle(10);
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("FAIL wrap_count got %0d expected 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_data[i] !== exp_d[i] || q_last[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL wrap_beat%0d got %h/%b expected %h/%b", i, q_data[i], q_last[i], exp_d[i], exp_l[i]);
        end
      end
      checks++;
      if (q_cyc[3] != acc_cyc + 5) begin errors++; $display("FAIL wrap_throughput got cycle %0d expected %0d", q_cyc[3], acc_cyc + 5); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [8];
    int          lasts;
    exp_d = '{32'h143, 32'h144, 32'h145, 32'h146, 32'h147, 32'h140, 32'h141, 32'h142};
    for (int i = 0; i < 8; i++) push_cmd(1'b1, 32'h40 + i, 32'h140 + i, 4'hF, 3'd2);
    idle(6);
    clear_q();
    rsp_full_n = 1'b0;
    push_cmd(1'b0, 32'h43, 32'h0, 4'h0, 3'd5);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 rsp_full_n = k[1];
    end
    rsp_full_n = 1'b1;
    idle(10);
    checks++;
    if (q_data.size() != 8) begin
      errors++;
      $display("FAIL bp_count got %0d expected 8", q_data.size());
    end else begin
      lasts = 0;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_data[i] !== exp_d[i]) begin errors++; $display("FAIL bp_beat%0d got %h expected %h", i, q_data[i], exp_d[i]); end
        if (q_last[i] === 1'b1) lasts++;
      end
      checks++;
      if (lasts != 1 || q_last[7] !== 1'b1) begin
        errors++;
        $display("FAIL bp_last got %0d lasts (final=%b) expected 1 on beat 7", lasts, q_last[7]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    clear_q();
    push_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'd5);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (q_data.size() < 3 && n < 50);
    checks++;
    if (q_data.size() != 3) begin errors++; $display("FAIL rst_burst_pre got %0d beats expected 3", q_data.size()); end
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    checks++;
    if (q_data.size() != 3) begin errors++; $display("FAIL rst_burst_post got %0d beats expected 3", q_data.size()); end
    clear_q();
    push_cmd(1'b0, 32'h41, 32'h0, 4'h0, 3'd2);
    idle(6);
    checks++;
    if (q_data.size() != 1) begin
      errors++;
      $display("FAIL rst_next_count got %0d expected 1", q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 32'h141 || q_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL rst_next_beat got %h/%b expected 00000141/1", q_data[0], q_last[0]);
      end
      checks++;
      if (q_cyc[0] != acc_cyc + 2) begin errors++; $display("FAIL rst_next_latency got cycle %0d expected %0d", q_cyc[0], acc_cyc + 2); end
    end
  endtask

  task automatic test_write_ack();
    clear_q();
    push_cmd(1'b1, 32'h50, 32'h55, 4'hF, 3'd2);
    idle(6);
    checks++;
    if (q_data.size() != ACK) begin
      errors++;
      $display("FAIL ack_count got %0d expected %0d", q_data.size(), ACK);
    end else if (ACK == 1) begin
      checks++;
      if (q_data[0] !== 32'h0 || q_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL ack_beat got %h/%b expected 00000000/1", q_data[0], q_last[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_wrap();
    test_backpressure();
    test_reset_mid_burst();
    test_write_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
